// File: rtl/frv_trace_pkg.sv
// Shared definitions for the FRV instruction trace buffer.
// The entry struct carries a fixed-width sequence field so one type can
// serve every SEQW setting; the buffer stores the low SEQW bits in it.
package frv_trace_pkg;

  // Widest sequence number an entry can carry.
  localparam int SEQ_MAXW = 32;

  // Saturation point of the dropped-record counter.
  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  // One captured trace record as held in the buffer storage.
  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [SEQ_MAXW-1:0] seq;
    logic                gap;
  } trace_entry_t;

  // Increment an 8-bit count, holding at DROP_CNT_MAX.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == DROP_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/frv_trace_ram.sv
// Trace entry storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. The array is deliberately not reset; the control
// logic in the buffer decides which entries are meaningful.
module frv_trace_ram
  import frv_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [AW-1:0] i_waddr,
  input  trace_entry_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output trace_entry_t o_rdata
);

  trace_entry_t r_mem [DEPTH];

  // Write the incoming record into its slot on the clock edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read side is purely combinational so the head entry falls through.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/frv_trace_buffer.sv
// First-word-fall-through trace buffer sitting between the core trace port
// and a slower sink. When the buffer is full and nothing leaves, incoming
// records are dropped; the drop is counted, flagged sticky, and the next
// record that does get stored is marked with a gap bit so the sink knows
// the stream is discontinuous there.
module frv_trace_buffer
  import frv_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQW  = 16
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     flush,
  input  logic                     trs_valid,
  input  logic [31:0]              trs_pc,
  input  logic [31:0]              trs_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [SEQW-1:0]          out_seq,
  output logic                     out_gap,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [OW-1:0]   r_occ;
  logic [SEQW-1:0] r_seq;
  logic [7:0]      r_drop_count;
  logic            r_overflow;
  logic            r_gap_pending;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  trace_entry_t    w_wdata;
  trace_entry_t    w_head;
  logic            w_unused_seq;

  // Handshake decode. Flush overrides everything, so neither a pop nor a
  // push nor a drop is recognised in a flush cycle. A full buffer still
  // accepts a record when the head leaves in the same cycle.
  assign w_full = (r_occ == OCC_FULL);
  assign w_pop  = out_valid && out_ready && !flush;
  assign w_push = trs_valid && !flush && (!w_full || w_pop);
  assign w_drop = trs_valid && !flush && w_full && !w_pop;

  // Record as it will be stored: the gap bit reports drops since the last
  // stored record, and the sequence number is the pre-increment value.
  always_comb begin
    w_wdata       = '0;
    w_wdata.pc    = trs_pc;
    w_wdata.instr = trs_instr;
    w_wdata.seq   = SEQ_MAXW'(r_seq);
    w_wdata.gap   = r_gap_pending;
  end

  frv_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (g_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Head entry is shown straight from storage; data is meaningless while
  // out_valid is low.
  assign out_valid    = (r_occ != '0);
  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_seq      = w_head.seq[SEQW-1:0];
  assign out_gap      = w_head.gap;
  assign occupancy    = r_occ;
  assign drop_count   = r_drop_count;
  assign overflow     = r_overflow;
  assign w_unused_seq = ^w_head.seq;

  // Read and write pointers; both wrap naturally because DEPTH is a power
  // of two, and a flush returns them to the start of the array.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Entry count: up on a lone push, down on a lone pop, unchanged when both
  // or neither happen.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sequence counter advances for every record the core offers, stored or
  // dropped. It survives a flush so numbering stays monotonic for the sink;
  // a record offered during the flush cycle is simply ignored.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_seq <= '0;
    end else if (w_push || w_drop) begin
      r_seq <= r_seq + SEQW'(1);
    end
  end

  // Drop bookkeeping: saturating counter, sticky overflow flag, and the
  // pending gap marker that the next stored record consumes.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_gap_pending <= 1'b0;
    end else if (flush) begin
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_gap_pending <= 1'b0;
    end else if (w_drop) begin
      r_drop_count  <= sat_inc8(r_drop_count);
      r_overflow    <= 1'b1;
      r_gap_pending <= 1'b1;
    end else if (w_push) begin
      r_gap_pending <= 1'b0;
    end
  end

endmodule
